// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use stalls,
// taken-branch flushes, mult/div occupancy of EX and the Stop drain/halt sequence.
//
//   state | meaning
//   RUN   | normal issue; load-use, branch, mult/div start and Stop are resolved
//   BUSY  | mult/div occupies EX; front end held, EX/MEM fed bubbles
//   DRAIN | Stop in flight; fetch held, older instructions retire
//   HALT  | Stop retired; pipeline frozen until reset
module pipe_hazard_ctrl #(
   parameter int MULDIV_LAT = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic       UsesRsD,
   input  logic       UsesRtD,
   input  logic       MemReadE,
   input  logic [4:0] RtE,
   input  logic       BranchTakenD,
   input  logic       MulDivStartE,
   input  logic       StopD,
   input  logic       StopW,
   output logic       StallF,
   output logic       StallD,
   output logic       FlushD,
   output logic       StallE,
   output logic       FlushE,
   output logic       FlushM,
   output logic       Halted,
   output logic [2:0] CtrlState
);

   typedef enum logic [2:0] {
      RUN   = 3'd0,
      BUSY  = 3'd1,
      DRAIN = 3'd2,
      HALT  = 3'd3
   } state_t;

   localparam logic [3:0] LAT_M1 = 4'(MULDIV_LAT - 1);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       lu;
   logic       stall_f, stall_d, flush_d, stall_e, flush_e, flush_m, halted;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      lu = MemReadE && (RtE != 5'd0) &&
           ((UsesRsD && (RsD == RtE)) || (UsesRtD && (RtD == RtE)));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      stall_e = 1'b0;
      flush_e = 1'b0;
      flush_m = 1'b0;
      halted  = 1'b0;
      case (state_q)
         RUN: begin
            if (MulDivStartE) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               stall_e = 1'b1;
               flush_m = 1'b1;
               cnt_d   = LAT_M1;
               if (MULDIV_LAT > 1) state_d = BUSY;
            end else if (lu) begin
               stall_f = 1'b1;
               stall_d = 1'b1;
               flush_e = 1'b1;
            end else if (BranchTakenD) begin
               flush_d = 1'b1;
            end else if (StopD) begin
               stall_f = 1'b1;
               state_d = DRAIN;
            end
         end
         BUSY: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
            cnt_d   = cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_d = RUN;
         end
         DRAIN: begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            if (StopW) state_d = HALT;
         end
         HALT: begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            halted  = 1'b1;
         end
         default: state_d = RUN;
      endcase
   end

   // Outputs are forced low while reset is held, even if RUN would react to inputs.
   assign StallF    = reset & stall_f;
   assign StallD    = reset & stall_d;
   assign FlushD    = reset & flush_d & ~stall_d;
   assign StallE    = reset & stall_e;
   assign FlushE    = reset & flush_e;
   assign FlushM    = reset & flush_m;
   assign Halted    = reset & halted;
   assign CtrlState = reset ? state_q : 3'd0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected output words queued with each
// stimulus cycle and compared a few ns after the falling edge.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] RsD, RtD, RtE;
   logic       UsesRsD, UsesRtD, MemReadE, BranchTakenD, MulDivStartE, StopD, StopW;

   logic       sf0, sd0, fd0, se0, fe0, fm0, h0;
   logic [2:0] cs0;
   logic       sf1, sd1, fd1, se1, fe1, fm1, h1;
   logic [2:0] cs1;

   // {StallF, StallD, FlushD, StallE, FlushE, FlushM, Halted}
   localparam logic [6:0] O_NONE = 7'b0000000;
   localparam logic [6:0] O_LU   = 7'b1100100;
   localparam logic [6:0] O_MD   = 7'b1101010;
   localparam logic [6:0] O_BR   = 7'b0010000;
   localparam logic [6:0] O_SF   = 7'b1000000;
   localparam logic [6:0] O_DR   = 7'b1010000;
   localparam logic [6:0] O_HL   = 7'b1100101;

   typedef struct {
      string      tag;
      bit         sel;
      logic [9:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   pipe_hazard_ctrl #(.MULDIV_LAT(4)) dut (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
      .MemReadE(MemReadE), .RtE(RtE), .BranchTakenD(BranchTakenD), .MulDivStartE(MulDivStartE),
      .StopD(StopD), .StopW(StopW), .StallF(sf0), .StallD(sd0), .FlushD(fd0), .StallE(se0),
      .FlushE(fe0), .FlushM(fm0), .Halted(h0), .CtrlState(cs0)
   );

   pipe_hazard_ctrl #(.MULDIV_LAT(1)) dut_lat1 (
      .clk(clk), .reset(reset), .RsD(RsD), .RtD(RtD), .UsesRsD(UsesRsD), .UsesRtD(UsesRtD),
      .MemReadE(MemReadE), .RtE(RtE), .BranchTakenD(BranchTakenD), .MulDivStartE(MulDivStartE),
      .StopD(StopD), .StopW(StopW), .StallF(sf1), .StallD(sd1), .FlushD(fd1), .StallE(se1),
      .FlushE(fe1), .FlushM(fm1), .Halted(h1), .CtrlState(cs1)
   );

   wire [9:0] obs0 = {sf0, sd0, fd0, se0, fe0, fm0, h0, cs0};
   wire [9:0] obs1 = {sf1, sd1, fd1, se1, fe1, fm1, h1, cs1};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic exp_push(input string tag, input bit sel, input logic [6:0] f, input int st);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = {f, 3'(st)};
      q.push_back(e);
   endtask

   task automatic idle();
      RsD = 5'd0; RtD = 5'd0; RtE = 5'd0;
      UsesRsD = 1'b0; UsesRtD = 1'b0; MemReadE = 1'b0;
      BranchTakenD = 1'b0; MulDivStartE = 1'b0; StopD = 1'b0; StopW = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      idle();
   endtask

   task automatic set_lu(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rte);
      RsD = rs; RtD = rt; UsesRsD = urs; UsesRtD = urt; MemReadE = 1'b1; RtE = rte;
   endtask

   always @(negedge clk) begin : checker_p
      exp_t e;
      #3;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.tag, e.sel ? obs1 : obs0, e.exp);
      end
   end

   initial begin
      reset = 1'b0;
      idle();
      tick();
      // Hazard inputs active during reset must not leak through.
      tick(); set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); exp_push("rst_gate", 0, O_NONE, 0);
      tick(); reset = 1'b1;                           exp_push("idle", 0, O_NONE, 0);

      tick(); set_lu(5'd5, 5'd0, 1'b1, 1'b0, 5'd5); exp_push("lu_rs", 0, O_LU, 0);
      tick();                                         exp_push("lu_clear", 0, O_NONE, 0);
      tick(); set_lu(5'd3, 5'd7, 1'b0, 1'b1, 5'd7); exp_push("lu_rt", 0, O_LU, 0);
      tick(); set_lu(5'd5, 5'd0, 1'b0, 1'b0, 5'd5); exp_push("lu_nouse", 0, O_NONE, 0);
      tick(); set_lu(5'd0, 5'd0, 1'b1, 1'b1, 5'd0); exp_push("lu_r0", 0, O_NONE, 0);

      tick(); set_lu(5'd9, 5'd0, 1'b1, 1'b0, 5'd9); BranchTakenD = 1'b1;
      exp_push("br_vs_lu", 0, O_LU, 0);
      tick(); BranchTakenD = 1'b1;                    exp_push("br_flush", 0, O_BR, 0);

      // Mult/div outranks load-use, branch and Stop; LAT=1 instance never enters BUSY.
      tick(); MulDivStartE = 1'b1; BranchTakenD = 1'b1; StopD = 1'b1;
      set_lu(5'd4, 5'd0, 1'b1, 1'b0, 5'd4);
      exp_push("md_prio", 0, O_MD, 0);
      exp_push("lat1_md", 1, O_MD, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); exp_push("md_busy", 0, O_MD, 1); exp_push("lat1_run", 1, O_NONE, 0);
      end
      tick(); exp_push("md_done", 0, O_NONE, 0);

      // LAT=4 with the mult/div held in EX by StallE.
      tick(); MulDivStartE = 1'b1; exp_push("md4_t0", 0, O_MD, 0);
      for (int i = 0; i < 3; i++) begin
         tick(); MulDivStartE = 1'b1; exp_push("md4_busy", 0, O_MD, 1);
      end
      tick(); exp_push("md4_free", 0, O_NONE, 0);

      // Stop arriving mid-BUSY waits for RUN, then drains and halts.
      tick(); MulDivStartE = 1'b1; exp_push("st_md", 0, O_MD, 0);
      tick(); MulDivStartE = 1'b1; exp_push("st_busy1", 0, O_MD, 1);
      tick(); MulDivStartE = 1'b1; StopD = 1'b1; BranchTakenD = 1'b1;
      exp_push("st_busy2", 0, O_MD, 1);
      tick(); MulDivStartE = 1'b1; StopD = 1'b1; exp_push("st_busy3", 0, O_MD, 1);
      tick(); StopD = 1'b1; exp_push("st_run", 0, O_SF, 0);
      tick(); exp_push("st_drain1", 0, O_DR, 2);
      tick(); set_lu(5'd6, 5'd0, 1'b1, 1'b0, 5'd6); BranchTakenD = 1'b1; MulDivStartE = 1'b1;
      exp_push("st_drain2", 0, O_DR, 2);
      tick(); StopW = 1'b1; exp_push("st_drain3", 0, O_DR, 2);
      tick(); exp_push("st_halt", 0, O_HL, 3);
      for (int i = 0; i < 20; i++) begin
         tick();
         RsD = 5'($urandom); RtD = 5'($urandom); RtE = 5'($urandom);
         UsesRsD = 1'($urandom); UsesRtD = 1'($urandom); MemReadE = 1'($urandom);
         BranchTakenD = 1'($urandom); MulDivStartE = 1'($urandom);
         StopD = 1'($urandom); StopW = 1'($urandom);
         exp_push("halt_hold", 0, O_HL, 3);
      end

      // Asynchronous reset while halted.
      tick(); exp_push("halt_pre", 0, O_HL, 3);
      #4 reset = 1'b0;
      #1 chk("halt_rst", obs0, {O_NONE, 3'd0});
      tick(); reset = 1'b1; exp_push("halt_rel", 0, O_NONE, 0);
      tick(); set_lu(5'd8, 5'd0, 1'b1, 1'b0, 5'd8); exp_push("post_lu", 0, O_LU, 0);
      tick(); exp_push("post_lu_clr", 0, O_NONE, 0);

      // Asynchronous reset in BUSY with cnt=2, mult/div still requested.
      tick(); MulDivStartE = 1'b1; exp_push("mr_md", 0, O_MD, 0);
      tick(); MulDivStartE = 1'b1; exp_push("mr_cnt3", 0, O_MD, 1);
      tick(); MulDivStartE = 1'b1; exp_push("mr_cnt2", 0, O_MD, 1);
      #4 reset = 1'b0;
      #1 chk("mr_rst", obs0, {O_NONE, 3'd0});
      tick(); reset = 1'b1; exp_push("mr_rel", 0, O_NONE, 0);
      tick(); exp_push("mr_norst", 0, O_NONE, 0);
      tick(); BranchTakenD = 1'b1; exp_push("mr_br", 0, O_BR, 0);

      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
